// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - fetch_state_t   : fetch sequencer states
//   - PC_INCREMENT    : distance between sequential instruction words
//   - WORD_ALIGN_BITS : number of low address bits that must be zero
//   - align_word      : clears the sub-word bits of an address
//   - is_misaligned   : flags an address that is not word aligned
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INCREMENT    = 32'd4;
  localparam int          WORD_ALIGN_BITS = 2;

  // Force an address onto a word boundary by zeroing the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}};
  endfunction

  // True when any byte-offset bit is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[WORD_ALIGN_BITS-1:0];
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// ---------------------------------------------------------------------------
// fetch_wait_counter
//   3-bit loadable down-counter used to time the instruction memory latency.
//   Ports:
//     clock       in   system clock, rising edge
//     resetSignal in   asynchronous active-high reset (count -> 0)
//     load        in   load load_value this cycle (wins over decrement)
//     load_value  in   value to load (latency - 1)
//     decrement   in   count down by one while nonzero
//     zero        out  count is zero
// ---------------------------------------------------------------------------
module fetch_wait_counter (
  input  logic       clock,
  input  logic       resetSignal,
  input  logic       load,
  input  logic [2:0] load_value,
  input  logic       decrement,
  output logic       zero
);

  logic [2:0] count;

  // Down-counter: load has priority, saturates at zero.
  always_ff @(posedge clock or posedge resetSignal) begin
    if (resetSignal) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != 3'd0)) begin
      count <= count - 3'd1;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch initiator for the multi-cycle MIPS datapath. Owns the PC, presents
//   it to instruction memory, captures the returned word into the IR after
//   MEM_LATENCY cycles and offers it to decode over a valid/ready handshake.
//   Branch/jump redirects from the control unit override everything.
//   Ports:
//     clock               in   system clock, rising edge
//     resetSignal         in   asynchronous active-high reset
//     fetchEnable         in   permits a new fetch to start
//     programCounter      out  address to instruction memory (PC register)
//     instruction         in   word returned by instruction memory
//     instructionRegister out  latched instruction (IR)
//     irValid             out  IR holds an unconsumed instruction
//     irReady             in   decode accepts the IR this cycle
//     currentPc           out  address of the instruction held in IR
//     redirectValid       in   load redirectTarget into the PC
//     redirectTarget      in   branch/jump target
//     misalignedError     out  one-cycle pulse for an unaligned target
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic        clock,
  input  logic        resetSignal,
  input  logic        fetchEnable,
  output logic [31:0] programCounter,
  input  logic [31:0] instruction,
  output logic [31:0] instructionRegister,
  output logic        irValid,
  input  logic        irReady,
  output logic [31:0] currentPc,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        misalignedError
);

  fetch_state_t state;
  logic         counter_zero;

  // The latency counter only exists when memory is not combinational. It is
  // loaded on the ISSUE cycle (unless a redirect is abandoning that fetch)
  // and counts down through WAIT; capture happens on the WAIT cycle where it
  // reads zero, i.e. after MEM_LATENCY cycles of address presentation.
  generate
    if (MEM_LATENCY > 32'd0) begin : g_wait
      localparam logic [2:0] WAIT_LOAD = 3'(MEM_LATENCY - 32'd1);
      logic counter_load;
      logic counter_dec;

      assign counter_load = (state == ISSUE) && !redirectValid;
      assign counter_dec  = (state == WAIT);

      fetch_wait_counter u_wait_counter (
        .clock       (clock),
        .resetSignal (resetSignal),
        .load        (counter_load),
        .load_value  (WAIT_LOAD),
        .decrement   (counter_dec),
        .zero        (counter_zero)
      );
    end else begin : g_no_wait
      assign counter_zero = 1'b1;
    end
  endgenerate

  // Fetch sequencer with registered outputs. Redirect outranks every state;
  // IR/currentPc change only on a capture, never on redirect.
  always_ff @(posedge clock or posedge resetSignal) begin
    if (resetSignal) begin
      state               <= IDLE;
      programCounter      <= RESET_PC;
      instructionRegister <= 32'h0000_0000;
      currentPc           <= RESET_PC;
      irValid             <= 1'b0;
      misalignedError     <= 1'b0;
    end else begin
      misalignedError <= 1'b0;
      if (redirectValid) begin
        // Covers redirect coinciding with irReady in HOLD: the IR counts as
        // consumed and the target wins over PC + 4.
        programCounter  <= align_word(redirectTarget);
        misalignedError <= is_misaligned(redirectTarget);
        irValid         <= 1'b0;
        state           <= fetchEnable ? ISSUE : IDLE;
      end else begin
        case (state)
          IDLE: begin
            irValid <= 1'b0;
            state   <= fetchEnable ? ISSUE : IDLE;
          end
          ISSUE: begin
            if (MEM_LATENCY == 32'd0) begin
              instructionRegister <= instruction;
              currentPc           <= programCounter;
              irValid             <= 1'b1;
              state               <= HOLD;
            end else begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (counter_zero) begin
              instructionRegister <= instruction;
              currentPc           <= programCounter;
              irValid             <= 1'b1;
              state               <= HOLD;
            end else begin
              state <= WAIT;
            end
          end
          HOLD: begin
            if (irReady) begin
              programCounter <= programCounter + PC_INCREMENT;
              irValid        <= 1'b0;
              state          <= fetchEnable ? ISSUE : IDLE;
            end else begin
              state <= HOLD;
            end
          end
          default: begin
            irValid <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: dut0 uses combinational memory, dut3 a 3-cycle memory.
// Inputs are shared; each phase checks only the instance it targets.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        rst;
  logic        fetch_enable;
  logic        ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] pc0, ir0, cur0, instr0;
  logic        valid0, mis0;
  logic [31:0] pc3, ir3, cur3, instr3;
  logic        valid3, mis3;

  logic [15:0] stamp;
  int          checks;
  int          errors;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(0)) dut0 (
    .clock               (clock),
    .resetSignal         (rst),
    .fetchEnable         (fetch_enable),
    .programCounter      (pc0),
    .instruction         (instr0),
    .instructionRegister (ir0),
    .irValid             (valid0),
    .irReady             (ir_ready),
    .currentPc           (cur0),
    .redirectValid       (redirect_valid),
    .redirectTarget      (redirect_target),
    .misalignedError     (mis0)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(3)) dut3 (
    .clock               (clock),
    .resetSignal         (rst),
    .fetchEnable         (fetch_enable),
    .programCounter      (pc3),
    .instruction         (instr3),
    .instructionRegister (ir3),
    .irValid             (valid3),
    .irReady             (ir_ready),
    .currentPc           (cur3),
    .redirectValid       (redirect_valid),
    .redirectTarget      (redirect_target),
    .misalignedError     (mis3)
  );

  // Memory for dut0: word 0 is fixed, other words encode their address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h2008_0005;
    return 32'hA000_0000 | addr;
  endfunction

  assign instr0 = mem_word(pc0);
  // dut3 memory word changes every cycle so the capture cycle is visible.
  assign instr3 = {pc3[15:0], stamp};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) stamp <= stamp + 16'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_ir [4];
    logic [31:0] held_ir, held_pc, held_cur;
    logic [15:0] s;

    exp_ir[0] = 32'h2008_0005;
    exp_ir[1] = 32'hA000_0004;
    exp_ir[2] = 32'hA000_0008;
    exp_ir[3] = 32'hA000_000C;
    checks = 0;
    errors = 0;
    stamp = 16'd0;
    rst = 1'b1;
    fetch_enable = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0000_0000;

    // Reset values before any clock edge.
    #3;
    check_eq("rst_pc", pc0, 32'h0);
    check_eq("rst_ir", ir0, 32'h0);
    check_eq("rst_cur", cur0, 32'h0);
    check_eq("rst_valid", {31'd0, valid0}, 32'h0);
    check_eq("rst_mis", {31'd0, mis0}, 32'h0);

    // ---------------- MEM_LATENCY = 0 sequential fetch ----------------
    tick();
    tick();
    rst = 1'b0;
    fetch_enable = 1'b1;
    ir_ready = 1'b1;
    tick();  // IDLE -> ISSUE
    for (int k = 0; k < 4; k++) begin
      check_eq("seq_issue_pc", pc0, 32'(4 * k));
      check_eq("seq_issue_valid", {31'd0, valid0}, 32'h0);
      tick();  // HOLD
      check_eq("seq_hold_valid", {31'd0, valid0}, 32'h1);
      check_eq("seq_hold_ir", ir0, exp_ir[k]);
      check_eq("seq_hold_cur", cur0, 32'(4 * k));
      tick();  // accepted -> ISSUE
    end
    check_eq("seq_final_pc", pc0, 32'h10);

    // ---------------- backpressure ----------------
    ir_ready = 1'b0;
    tick();  // HOLD at 0x10
    held_ir = ir0;
    held_pc = pc0;
    held_cur = cur0;
    check_eq("bp_ir_value", held_ir, 32'hA000_0010);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, valid0}, 32'h1);
      check_eq("bp_ir", ir0, 32'hA000_0010);
      check_eq("bp_cur", cur0, 32'h10);
      check_eq("bp_pc", pc0, 32'h10);
      tick();
    end
    ir_ready = 1'b1;
    tick();
    check_eq("bp_release_pc", pc0, 32'h14);
    check_eq("bp_release_valid", {31'd0, valid0}, 32'h0);

    // ---------------- misaligned redirect (from ISSUE) ----------------
    ir_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0042;
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_pulse", {31'd0, mis0}, 32'h1);
    check_eq("mis_pc", pc0, 32'h40);
    check_eq("mis_valid", {31'd0, valid0}, 32'h0);
    tick();  // HOLD with word at 0x40
    check_eq("mis_pulse_end", {31'd0, mis0}, 32'h0);
    check_eq("mis_cur", cur0, 32'h40);
    check_eq("mis_ir", ir0, 32'hA000_0040);
    check_eq("mis_hold_valid", {31'd0, valid0}, 32'h1);

    // ---------------- redirect together with irReady in HOLD ----------------
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    check_eq("rdr_ack_pc", pc0, 32'h100);
    check_eq("rdr_ack_valid", {31'd0, valid0}, 32'h0);
    check_eq("rdr_ack_mis", {31'd0, mis0}, 32'h0);
    check_eq("rdr_keep_ir", ir0, 32'hA000_0040);
    check_eq("rdr_keep_cur", cur0, 32'h40);

    // ---------------- wrap at top of address space ----------------
    redirect_target = 32'hFFFF_FFFC;
    tick();  // redirect while in ISSUE
    redirect_valid = 1'b0;
    check_eq("wrap_pc", pc0, 32'hFFFF_FFFC);
    tick();  // HOLD
    check_eq("wrap_cur", cur0, 32'hFFFF_FFFC);
    check_eq("wrap_ir", ir0, 32'hFFFF_FFFC);
    tick();  // accepted
    check_eq("wrap_next_pc", pc0, 32'h0);

    // ---------------- MEM_LATENCY = 3 ----------------
    rst = 1'b1;
    fetch_enable = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    fetch_enable = 1'b1;
    tick();  // ISSUE entry
    s = stamp;
    check_eq("lat_issue_pc", pc3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("lat_not_valid", {31'd0, valid3}, 32'h0);
      tick();
    end
    // Four edges after ISSUE entry: valid with the final-WAIT-cycle word.
    check_eq("lat_valid", {31'd0, valid3}, 32'h1);
    check_eq("lat_ir", ir3, {16'h0000, s + 16'd3});
    check_eq("lat_cur", cur3, 32'h0);

    ir_ready = 1'b1;
    tick();  // accepted -> ISSUE at 4
    ir_ready = 1'b0;
    check_eq("lat_accept_pc", pc3, 32'h4);
    tick();  // WAIT
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();  // redirect during WAIT -> ISSUE at 0x40
    redirect_valid = 1'b0;
    check_eq("wr_pc", pc3, 32'h40);
    s = stamp;
    for (int i = 0; i < 4; i++) begin
      check_eq("wr_dropped_valid", {31'd0, valid3}, 32'h0);
      tick();
    end
    check_eq("wr_valid", {31'd0, valid3}, 32'h1);
    check_eq("wr_cur", cur3, 32'h40);
    check_eq("wr_ir", ir3, {16'h0040, s + 16'd3});

    // ---------------- async reset mid-WAIT ----------------
    ir_ready = 1'b1;
    tick();  // ISSUE at 0x44
    ir_ready = 1'b0;
    tick();  // WAIT
    check_eq("ar_pre_pc", pc3, 32'h44);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_pc", pc3, 32'h0);
    check_eq("ar_ir", ir3, 32'h0);
    check_eq("ar_cur", cur3, 32'h0);
    check_eq("ar_valid", {31'd0, valid3}, 32'h0);
    check_eq("ar_mis", {31'd0, mis3}, 32'h0);
    tick();
    check_eq("ar_hold_pc", pc3, 32'h0);
    check_eq("ar_hold_valid", {31'd0, valid3}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch initiator for the multi-cycle MIPS datapath.
- Owns the PC register and drives `programCounter` into InstructionMemoryUnit. Samples the returned `instruction` after a fixed memory latency and latches it into the instruction register (IR).
- Presents the IR to the decode/control FSM over a valid/ready handshake. Accepts branch/jump redirects from the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_LATENCY, 0, cycles between address presentation and valid instruction (0..7). 0 = combinational memory (current InstructionMemoryUnit).

Ports:
- clock  in  1  system clock, rising edge.
- resetSignal  in  1  asynchronous, active-high reset.
- fetchEnable  in  1  permits new fetches to start.
- programCounter  out  32  address to InstructionMemoryUnit, driven directly from the PC register.
- instruction  in  32  instruction word returned by memory.
- instructionRegister  out  32  latched instruction.
- irValid  out  1  IR holds an unconsumed instruction.
- irReady  in  1  decode accepts IR this cycle.
- currentPc  out  32  address of the instruction held in IR.
- redirectValid  in  1  load new PC (branch/jump).
- redirectTarget  in  32  new PC value.
- misalignedError  out  1  one-cycle pulse: redirectTarget[1:0] != 0.

Behaviour:
- Reset (async, any state):
  - PC = RESET_PC; instructionRegister = 0; currentPc = RESET_PC.
  - irValid = 0; misalignedError = 0; state = IDLE; wait counter = 0.
  - Any in-flight fetch is abandoned.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: irValid = 0. fetchEnable = 1 -> ISSUE next cycle.
- ISSUE:
  - programCounter = PC (stable through WAIT and HOLD).
  - MEM_LATENCY = 0: IR <= instruction and currentPc <= PC at the end of this cycle; -> HOLD.
  - Otherwise: load wait counter with MEM_LATENCY-1; -> WAIT.
- WAIT: decrement the counter each cycle. At count 0: IR <= instruction, currentPc <= PC; -> HOLD. Latency from ISSUE entry to irValid = MEM_LATENCY+1 cycles.
- HOLD:
  - irValid = 1. IR, currentPc and PC are held until irReady.
  - irReady = 1: handshake completes and PC <= PC + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - After the handshake, go to ISSUE if fetchEnable = 1, else IDLE. irValid drops the next cycle; there is no back-to-back valid because every fetch passes through ISSUE.
- fetchEnable deasserted in ISSUE/WAIT: the fetch completes into HOLD. fetchEnable only gates starting a new fetch.
- Redirect (redirectValid = 1, any non-reset state, highest priority):
  - PC <= {redirectTarget[31:2], 2'b00}.
  - Any pending fetch or un-accepted IR is discarded; irValid = 0 the next cycle.
  - Next state: ISSUE if fetchEnable = 1, else IDLE.
- Redirect and irReady in the same HOLD cycle: the handshake counts as accepted and PC takes the redirect target, not PC+4.
- Misaligned target: misalignedError = 1 for exactly the cycle after a redirect with target[1:0] != 0. The PC still loads the aligned value.
- IR and currentPc update only on a capture; they are never cleared by a redirect (only irValid is).

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, ISSUE, WAIT, HOLD).
  - PC_INCREMENT = 32'd4.
  - WORD_ALIGN_BITS = 2.
- One sub-module, fetch_wait_counter: 3-bit loadable down-counter with a load input, load value and zero flag. Instantiated only when MEM_LATENCY > 0.

Test Plan:
- Reset and first fetch, MEM_LATENCY=0, memory word 0 = 32'h2008_0005: release reset, fetchEnable=1, irReady=1.
  - programCounter 32'h0 -> 32'h4 -> 32'h8 -> 32'hC -> 32'h10.
  - irValid pulses once per 2-cycle fetch; currentPc tracks; IR = mem[PC>>2].
- Backpressure: hold irReady=0 for 5 cycles in HOLD.
  - irValid stays 1; IR, currentPc and programCounter stay constant.
  - irReady=1 -> PC advances by exactly 4.
- Latency, MEM_LATENCY=3: irValid first asserts 4 cycles after ISSUE entry. The IR captures the value memory presents on the final WAIT cycle, not earlier values.
- Redirect:
  - During WAIT, redirectTarget=32'h40: the pending fetch is dropped and the next IR has currentPc=32'h40.
  - redirectTarget=32'h42: misalignedError pulses 1 cycle and PC=32'h40.
  - Redirect coinciding with irReady in HOLD: PC becomes the target, not PC+4.
- Wrap and reset mid-operation:
  - Redirect to 32'hFFFF_FFFC, accept the IR: next programCounter = 32'h0.
  - Assert resetSignal asynchronously mid-WAIT: all outputs return to reset values immediately, with no clock edge needed.
